gc_stream_packer: RTL



---
 rtl/gc_stream_pkg.sv | 33 +++
 rtl/gc_fifo_2w1r.sv | 58 +++++
 rtl/gc_stream_packer.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/gc_stream_pkg.sv
// Shared types and tag decode constants for the GC stream packer.
// Record layout is the FIFO word: type, cid, index, data.
package gc_stream_pkg;

  typedef enum logic [1:0] {
    LABEL = 2'd0,
    KEY   = 2'd1,
    TABLE = 2'd2,
    MASK  = 2'd3
  } out_type_e;

  localparam logic [2:0] TAG_KEY   = 3'b001;
  localparam logic [2:0] TAG_TABLE = 3'b010;
  localparam logic [2:0] TAG_MASK  = 3'b011;
  localparam int         TAG_LABEL_BIT = 2;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int REC_K = 128;
  localparam int REC_S = 16;

  typedef struct packed {
    out_type_e        typ;
    logic [REC_S-1:0] cid;
    logic [REC_S-1:0] index;
    logic [REC_K-1:0] data;
  } gc_rec_t;

endpackage

// File: rtl/gc_fifo_2w1r.sv
// FIFO with two ordered write ports and one first-word-fall-through read.
// Caller guarantees writes never exceed free space and reads never underflow.
import gc_stream_pkg::*;

module gc_fifo_2w1r #(
  parameter int WIDTH = 162,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we0,
  input  logic [WIDTH-1:0]         wd0,
  input  logic                     we1,
  input  logic [WIDTH-1:0]         wd1,
  input  logic                     re,
  output logic [WIDTH-1:0]         rd,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [AW:0]      cnt_q, cnt_d;

  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q + AW'(we0) + AW'(we1);
    rptr_d = rptr_q + AW'(re);
    cnt_d  = cnt_q + (AW+1)'(we0) + (AW+1)'(we1)
           - (AW+1)'(re);
    if (we0) mem_d[wptr_q] = wd0;
    // lane1 lands behind lane0 when both write
    if (we1) mem_d[we0 ? wptr_q + AW'(1) : wptr_q] = wd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rd    = mem_q[rptr_q];
  assign count = cnt_q;

endmodule

// File: rtl/gc_stream_packer.sv
// Packs the dual-lane GC output bus into one tagged valid/ready stream,
// with drop-on-overflow, per-type counters and end-of-run draining.
import gc_stream_pkg::*;

module gc_stream_packer #(
  parameter int K         = 128,
  parameter int S         = 16,
  parameter int CC        = 4,
  parameter int DEPTH     = 16,
  parameter int AF_MARGIN = 4,
  parameter int CW        = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [2:0]    tag,
  input  logic [S-1:0]  cid,
  input  logic [S-1:0]  index0,
  input  logic [S-1:0]  index1,
  input  logic [K-1:0]  data0,
  input  logic [K-1:0]  data1,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [1:0]    out_type,
  output logic [S-1:0]  out_cid,
  output logic [S-1:0]  out_index,
  output logic [K-1:0]  out_data,
  output logic          almost_full,
  output logic          overflow,
  output logic          done,
  output logic [CW-1:0] cnt_label,
  output logic [CW-1:0] cnt_key,
  output logic [CW-1:0] cnt_table,
  output logic [CW-1:0] cnt_mask
);

  localparam int AW = $clog2(DEPTH);
  localparam int W  = 2 + 2*S + K;

  state_e          state_q, state_d;
  logic            ovf_q, ovf_d;
  logic            af_q, af_d;
  logic [CW-1:0]   cnt_q [4];
  logic [CW-1:0]   cnt_d [4];

  logic            we0, we1;
  out_type_e       typ;
  logic [S-1:0]    idx0, idx1;
  logic [1:0]      n;
  logic [AW:0]     count, free, count_nxt;
  logic            in_run, end_hit, fits;
  logic            push_ok, push0, push1, drop, pop;
  logic [W-1:0]    head;

  always_comb begin
    we0  = 1'b0;
    we1  = 1'b0;
    typ  = LABEL;
    idx0 = index0;
    idx1 = index1;
    unique case (1'b1)
      tag[TAG_LABEL_BIT]: begin
        we0 = tag[0];
        we1 = tag[1];
      end
      tag == TAG_KEY: begin
        we0  = 1'b1;
        we1  = 1'b1;
        typ  = KEY;
        idx0 = '0;
        idx1 = S'(1);
      end
      tag == TAG_TABLE: begin
        we0 = 1'b1;
        we1 = 1'b1;
        typ = TABLE;
      end
      tag == TAG_MASK: begin
        we0  = 1'b1;
        typ  = MASK;
        idx0 = '0;
      end
      default: ;
    endcase
  end

  assign n       = {1'b0, we0} + {1'b0, we1};
  assign free    = (AW+1)'(DEPTH) - count;
  assign in_run  = (state_q == RUN);
  assign end_hit = in_run && (cid == S'(CC));
  assign fits    = (AW+1)'(n) <= free;
  // a cycle's words are taken together or not at all
  assign push_ok = in_run && !end_hit && fits;
  assign push0   = push_ok && we0;
  assign push1   = push_ok && we1;
  assign drop    = in_run && !end_hit && (n != 2'd0) && !fits;

  assign out_valid = (count != '0) && (state_q != DONE);
  assign pop       = out_valid && out_ready;
  assign count_nxt = count + (AW+1)'(push0) + (AW+1)'(push1)
                   - (AW+1)'(pop);

  always_comb begin
    af_d  = count_nxt >= (AW+1)'(DEPTH - AF_MARGIN);
    ovf_d = ovf_q || drop;
    cnt_d = cnt_q;
    if (push_ok) cnt_d[typ] = cnt_q[typ] + CW'(n);
    state_d = state_q;
    unique case (state_q)
      RUN:     if (end_hit) state_d = DRAIN;
      DRAIN:   if (count == '0) state_d = DONE;
      DONE:    state_d = DONE;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      ovf_q   <= 1'b0;
      af_q    <= 1'b0;
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else begin
      state_q <= state_d;
      ovf_q   <= ovf_d;
      af_q    <= af_d;
      cnt_q   <= cnt_d;
    end
  end

  gc_fifo_2w1r #(
    .WIDTH (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .we0   (push0),
    .wd0   ({typ, cid, idx0, data0}),
    .we1   (push1),
    .wd1   ({typ, cid, idx1, data1}),
    .re    (pop),
    .rd    (head),
    .count (count)
  );

  assign out_type  = out_valid ? head[K+2*S +: 2] : '0;
  assign out_cid   = out_valid ? head[K+S +: S]   : '0;
  assign out_index = out_valid ? head[K +: S]     : '0;
  assign out_data  = out_valid ? head[K-1:0]      : '0;

  assign almost_full = af_q;
  assign overflow    = ovf_q;
  assign done        = (state_q == DONE);
  assign cnt_label   = cnt_q[0];
  assign cnt_key     = cnt_q[1];
  assign cnt_table   = cnt_q[2];
  assign cnt_mask    = cnt_q[3];

endmodule
